tt_um_noah_harman: RTL and testbench
====================================

# tt_um_noah_harman

Tiny Tapeout user block: an SPI-configurable register bank that drives 16 output pins, each of which is held low, held high, or PWM-modulated at about 3 kHz. An external SPI controller writes five 8-bit registers over a write-only mode-0 link on `ui_in[2:0]`. The block sits at the top level of the tile, directly between the TT pad ring and the user logic.

## Interface
- Parameters: none (prescaler value fixed at 13; system clock 10 MHz nominal).
- `clk`  in  1  system clock, 10 MHz nominal.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ena`  in  1  tile-selected flag; ignored.
- `ui_in`  in  8  [0]=SCLK, [1]=COPI, [2]=nCS (active-low); [7:3] unused.
- `uo_out`  out  8  output channels 7..0.
- `uio_in`  in  8  unused.
- `uio_out`  out  8  output channels 15..8.
- `uio_oe`  out  8  constant 8'hFF (all bidirectionals are outputs).

## Operation
- Input sync: SCLK, COPI and nCS each pass through a 2-flop synchronizer into `clk`. SCLK rising and falling edges and nCS rising edges are detected from the synchronized signals.
- SPI frame, mode 0, MSB first, sampled on SCLK rising edge while nCS is low:
  - bit 15: R/W (1 = write);
  - bits 14:8: 7-bit address;
  - bits 7:0: data.
- nCS falling edge clears the bit counter and the shift register.
- Bits arriving after the 16th are ignored.
- Commit happens on nCS rising edge, only when all of these hold:
  - exactly 16 bits were received;
  - R/W = 1;
  - address ≤ 0x04.
- Otherwise the frame is discarded and no register changes. Reads are unsupported: nothing is driven back and COPI is not echoed.
- Register map (all reset to 0x00):
  - 0x00 `en_out[7:0]`
  - 0x01 `en_out[15:8]`
  - 0x02 `en_pwm[7:0]`
  - 0x03 `en_pwm[15:8]`
  - 0x04 `duty`
- PWM timebase:
  - 4-bit prescaler counts 0..12 and wraps to 0.
  - On wrap, an 8-bit `pwm_cnt` increments, wrapping 255→0.
  - Period = 13×256 = 3328 clk cycles (≈3.005 kHz at 10 MHz).
- `pwm_sig`:
  - duty = 0xFF: constant 1;
  - otherwise: `pwm_cnt < duty`;
  - duty = 0x00 therefore gives constant 0.
- Channel i output:
  - `en_out[i]` = 0: output 0;
  - else `en_pwm[i]` = 1: output `pwm_sig`;
  - else: output 1.
- Channel mapping: `uo_out = ch[7:0]`, `uio_out = ch[15:8]`.

## Timing
- Reset: while `rst_n` is low at a `clk` edge, all of the following are cleared:
  - all registers;
  - synchronizer flops, with nCS synchronizer flops preset to 1 (idle);
  - bit counter, shift register, prescaler and `pwm_cnt`.
- Outputs during and after reset: `uo_out` = 0x00, `uio_out` = 0x00, `uio_oe` = 0xFF.
- SCLK high and low phases must each last ≥ 4 clk cycles; nCS setup/hold around SCLK edges must be ≥ 4 clk cycles.
- Register write latency: the new value is visible on outputs ≤ 5 clk cycles after the nCS pin rises. This is synchronizer delay plus 1 commit cycle.
- `duty` and enable changes act immediately on the next compare; the PWM counter is not restarted.
- Reset during a frame aborts it; the frame must be re-sent after reset.
- A new nCS falling edge without a prior rising edge cannot occur. A glitch shorter than 2 clk cycles may be missed.

## Test plan
- Reset: hold `rst_n` = 0 for 5 cycles, then release. Expect `uo_out` = 0x00, `uio_out` = 0x00, `uio_oe` = 0xFF.
- Static outputs:
  - write 0x00 ← 0xF0 → `uo_out` = 0xF0;
  - write 0x01 ← 0xCC → `uio_out` = 0xCC.
- PWM 50%: write 0x00 ← 0x01, 0x02 ← 0x01, 0x04 ← 0x80. Expect `uo_out[0]`:
  - period 3328 ±13 cycles;
  - high time 1664 ±13 cycles.
- Duty extremes, with the same enables:
  - duty 0x00 → `uo_out[0]` constant 0 over 4000 cycles;
  - duty 0xFF → constant 1 over 4000 cycles.
- Rejected frames: each leaves all outputs unchanged.
  - frame with R/W = 0 (0x0055 sent to addr 0x00);
  - write to addr 0x05 or 0x7F;
  - 10-bit frame aborted by nCS rising early.
- Back-to-back writes: 0x00 ← 0xFF then 0x02 ← 0x0F. Expect:
  - `uo_out[7:4]` = 0xF;
  - `uo_out[3:0]` PWM with the current duty.

Source files
------------

// File: rtl/tt_um_noah_harman.sv
// Purpose: SPI-configurable 16-channel output driver; each channel is held low, held high or PWM'd (~3 kHz).
// Latency: a committed SPI write reaches the pins 3 clk cycles after the nCS pin rises (2-flop sync + commit).
// Backpressure: none; write-only SPI link, frames that are malformed or out of range are silently dropped.
// Ports: ui_in[0]=SCLK, ui_in[1]=COPI, ui_in[2]=nCS (active-low); uo_out=ch[7:0], uio_out=ch[15:8],
//        uio_oe tied to all-outputs; ena, uio_in and ui_in[7:3] are unused.
module tt_um_noah_harman (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam logic [3:0] PRESC_MAX = 4'd12;

    // Bits [1:0] are the synchronizer pair, bit [2] is the previous synchronized value for edge detection.
    logic [2:0] sclk_sync;
    logic [2:0] ncs_sync;
    logic [1:0] copi_sync;

    logic       sclk_rise;
    logic       ncs_fall;
    logic       ncs_rise;
    logic       ncs_low;

    logic [4:0]  bit_cnt;
    logic [15:0] shift_reg;
    logic        frame_ok;

    logic [7:0] en_out_lo;
    logic [7:0] en_out_hi;
    logic [7:0] en_pwm_lo;
    logic [7:0] en_pwm_hi;
    logic [7:0] duty;

    logic [3:0]  presc;
    logic [7:0]  pwm_cnt;
    logic        pwm_sig;
    logic [15:0] ch;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in};

    // Input synchronizers; nCS resets to 1 so reset release never looks like a frame start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= 3'b000;
            copi_sync <= 2'b00;
            ncs_sync  <= 3'b111;
        end else begin
            sclk_sync <= {sclk_sync[1:0], ui_in[0]};
            copi_sync <= {copi_sync[0], ui_in[1]};
            ncs_sync  <= {ncs_sync[1:0], ui_in[2]};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign ncs_fall  = ~ncs_sync[1] & ncs_sync[2];
    assign ncs_rise  = ncs_sync[1] & ~ncs_sync[2];
    assign ncs_low   = ~ncs_sync[1];

    // Bit counter saturates at 17 so that an over-long frame is distinguishable from an exact 16-bit one;
    // only the first 16 bits are shifted in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt   <= 5'd0;
            shift_reg <= 16'h0000;
        end else if (ncs_fall) begin
            bit_cnt   <= 5'd0;
            shift_reg <= 16'h0000;
        end else if (ncs_low && sclk_rise && (bit_cnt != 5'd17)) begin
            if (bit_cnt < 5'd16) begin
                shift_reg <= {shift_reg[14:0], copi_sync[1]};
            end
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    assign frame_ok = ncs_rise && (bit_cnt == 5'd16) && shift_reg[15] && (shift_reg[14:8] <= 7'd4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_out_lo <= 8'h00;
            en_out_hi <= 8'h00;
            en_pwm_lo <= 8'h00;
            en_pwm_hi <= 8'h00;
            duty      <= 8'h00;
        end else if (frame_ok) begin
            case (shift_reg[10:8])
                3'd0:    en_out_lo <= shift_reg[7:0];
                3'd1:    en_out_hi <= shift_reg[7:0];
                3'd2:    en_pwm_lo <= shift_reg[7:0];
                3'd3:    en_pwm_hi <= shift_reg[7:0];
                default: duty      <= shift_reg[7:0];
            endcase
        end
    end

    // PWM timebase: prescaler 0..12, pwm_cnt advances once per prescaler wrap (period 13*256 clk).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc   <= 4'd0;
            pwm_cnt <= 8'd0;
        end else if (presc == PRESC_MAX) begin
            presc   <= 4'd0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            presc <= presc + 4'd1;
        end
    end

    // 0xFF is special-cased so full scale is truly constant high rather than 255/256.
    assign pwm_sig = (duty == 8'hFF) || (pwm_cnt < duty);

    assign ch = {en_out_hi, en_out_lo} & (~{en_pwm_hi, en_pwm_lo} | {16{pwm_sig}});

    assign uo_out  = ch[7:0];
    assign uio_out = ch[15:8];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_noah_harman.sv
module tb_tt_um_noah_harman;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests = 0;
    int fails = 0;

    // Register image as seen by the SPI master: index = register address.
    logic [7:0] m_reg [0:4];

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        logic [7:0]  uo;
        logic [7:0]  uio;
    } vec_t;

    vec_t vt [12];

    always #50 clk = ~clk;

    tt_um_noah_harman dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp,
                           input logic [15:0] mask);
        tests++;
        if ((act & mask) !== (exp & mask)) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (mask %h)", name, act, exp, mask);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    endtask

    task automatic model_apply(input logic [15:0] w, input int nbits);
        int addr;
        addr = int'(w[14:8]);
        if (nbits == 16 && w[15] == 1'b1 && addr <= 4) m_reg[addr] = w[7:0];
    endtask

    // Expected pin image; channels whose level depends on PWM phase are masked out.
    task automatic model_expect(output logic [15:0] exp, output logic [15:0] mask);
        logic [15:0] en_o;
        logic [15:0] en_p;
        en_o = {m_reg[1], m_reg[0]};
        en_p = {m_reg[3], m_reg[2]};
        exp  = 16'h0000;
        mask = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            if (!en_o[i])               exp[i] = 1'b0;
            else if (!en_p[i])          exp[i] = 1'b1;
            else if (m_reg[4] == 8'h00) exp[i] = 1'b0;
            else if (m_reg[4] == 8'hFF) exp[i] = 1'b1;
            else                        mask[i] = 1'b0;
        end
    endtask

    task automatic check_model(input string name);
        logic [15:0] exp;
        logic [15:0] mask;
        model_expect(exp, mask);
        check16(name, {uio_out, uo_out}, exp, mask);
    endtask

    // Mode-0 SPI write, MSB first, 5 clk per SCLK phase; returns 5 clk after nCS rises.
    task automatic spi_frame(input logic [15:0] w, input int nbits);
        @(negedge clk);
        ui_in[2] = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            ui_in[1] = w[15 - i];
            repeat (5) @(negedge clk);
            ui_in[0] = 1'b1;
            repeat (5) @(negedge clk);
            ui_in[0] = 1'b0;
        end
        repeat (5) @(negedge clk);
        ui_in[2] = 1'b1;
        ui_in[1] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] w, input int nbits);
        spi_frame(w, nbits);
        model_apply(w, nbits);
    endtask

    task automatic wait_bit0(input logic val, input int budget, output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (uo_out[0] == val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ui_in = 8'h04;
        repeat (5) @(negedge clk);
        model_reset();
    endtask

    initial begin
        #9_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   hi_t;
        int   lo_t;
        int   ones;
        int   zeros;
        int   mixed;
        logic ok;
        logic ok2;
        logic [15:0] w;

        vt[0]  = '{16'h80F0, 16, 8'hF0, 8'h00};
        vt[1]  = '{16'h81CC, 16, 8'hF0, 8'hCC};
        vt[2]  = '{16'h0055, 16, 8'hF0, 8'hCC};
        vt[3]  = '{16'h8555, 16, 8'hF0, 8'hCC};
        vt[4]  = '{16'hFF55, 16, 8'hF0, 8'hCC};
        vt[5]  = '{16'h8033, 10, 8'hF0, 8'hCC};
        vt[6]  = '{16'h83FF, 16, 8'hF0, 8'h00};
        vt[7]  = '{16'h84FF, 16, 8'hF0, 8'hCC};
        vt[8]  = '{16'h82F0, 16, 8'hF0, 8'hCC};
        vt[9]  = '{16'h8400, 16, 8'h00, 8'h00};
        vt[10] = '{16'h8300, 16, 8'h00, 8'hCC};
        vt[11] = '{16'h8200, 16, 8'hF0, 8'hCC};

        ena    = 1'b1;
        uio_in = 8'h00;
        rst_n  = 1'b0;
        ui_in  = 8'h04;
        model_reset();

        // Reset state, during and after reset.
        repeat (5) @(negedge clk);
        check16("reset_pins", {uio_out, uo_out}, 16'h0000, 16'hFFFF);
        check16("reset_oe", {8'h00, uio_oe}, 16'h00FF, 16'hFFFF);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check16("post_reset_pins", {uio_out, uo_out}, 16'h0000, 16'hFFFF);
        check16("post_reset_oe", {8'h00, uio_oe}, 16'h00FF, 16'hFFFF);

        // Static writes, rejected frames and constant-duty PWM channels.
        for (int i = 0; i < 12; i++) begin
            do_write(vt[i].frame, vt[i].nbits);
            check16($sformatf("vec%0d", i), {uio_out, uo_out}, {vt[i].uio, vt[i].uo}, 16'hFFFF);
        end

        // PWM 50%: channel 0 only.
        do_write(16'h8001, 16);
        do_write(16'h8101, 16);
        do_write(16'h8201, 16);
        do_write(16'h8300, 16);
        do_write(16'h8480, 16);
        wait_bit0(1'b0, 4000, n, ok);
        wait_bit0(1'b1, 4000, n, ok2);
        check_range("pwm_align", int'(ok && ok2), 1, 1);
        wait_bit0(1'b0, 4000, hi_t, ok);
        wait_bit0(1'b1, 4000, lo_t, ok2);
        if (!(ok && ok2)) begin
            hi_t = 0;
            lo_t = 0;
        end
        check_range("pwm_high", hi_t, 1664 - 13, 1664 + 13);
        check_range("pwm_period", hi_t + lo_t, 3328 - 13, 3328 + 13);

        // Duty extremes.
        do_write(16'h8400, 16);
        ones = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (uo_out[0]) ones++;
        end
        check_range("duty00_ones", ones, 0, 0);
        do_write(16'h84FF, 16);
        ones = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (uo_out[0]) ones++;
        end
        check_range("dutyFF_ones", ones, 4000, 4000);

        // Back-to-back writes with duty 0x80.
        do_write(16'h8480, 16);
        do_write(16'h80FF, 16);
        do_write(16'h820F, 16);
        check16("b2b_static", {8'h00, uo_out}, 16'h00F0, 16'h00F0);
        ones  = 0;
        zeros = 0;
        mixed = 0;
        for (int i = 0; i < 3328; i++) begin
            @(negedge clk);
            if (uo_out[7:4] != 4'hF) mixed++;
            if (uo_out[3:0] == 4'hF) ones++;
            else if (uo_out[3:0] == 4'h0) zeros++;
            else mixed++;
        end
        check_range("b2b_consistent", mixed, 0, 0);
        check_range("b2b_high", ones, 1664 - 13, 1664 + 13);

        // Reset in the middle of a frame aborts it and clears everything.
        @(negedge clk);
        ui_in[2] = 1'b0;
        repeat (6) @(negedge clk);
        ui_in[1] = 1'b1;
        ui_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        apply_reset();
        check16("midframe_reset", {uio_out, uo_out}, 16'h0000, 16'hFFFF);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_write(16'h8155, 16);
        check16("after_reset_write", {uio_out, uo_out}, 16'h5500, 16'hFFFF);

        // Randomized frames against the register-level model.
        for (int i = 0; i < 40; i++) begin
            int nb;
            logic [6:0] addr;
            addr = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'($urandom_range(0, 6));
            w    = {($urandom_range(0, 3) != 0), addr, 8'($urandom)};
            nb   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : 16;
            do_write(w, nb);
            check_model($sformatf("rand%0d_%h_%0d", i, w, nb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
